// File: rtl/sorted_display_pkg.sv
// ============================================================================
//  Module   : sorted_display_pkg
//  Brief    : Shared types and constants for the sorted-value display back end.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package sorted_display_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   localparam int         NUM_DIGITS = 4;
   localparam logic [6:0] SEG_BLANK  = 7'h7F;

   // Active-low glyphs, bit order {g,f,e,d,c,b,a}, indexed by hex value
   localparam logic [6:0] HEX_GLYPH [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

`default_nettype wire

// File: rtl/sorted_display_hex.sv
// ============================================================================
//  Module   : hex_to_seg7
//  Brief    : Combinational 4-bit to active-low seven-segment glyph decoder.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module hex_to_seg7
   import sorted_display_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg_n
);

   assign seg_n = HEX_GLYPH[hex];

endmodule

`default_nettype wire

// File: rtl/sorted_display.sv
// ============================================================================
//  Module   : sorted_display
//  Brief    : Captures four sorted nibbles on a synchronised start_display edge
//             and scans them on a 4-digit common-anode seven-segment display.
//             Optional blinking is compiled in with SORTED_DISPLAY_BLINK_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sorted_display
   import sorted_display_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter int BLINK_DIV   = 256
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_display,
   input  logic [3:0] sorted_num0,
   input  logic [3:0] sorted_num1,
   input  logic [3:0] sorted_num2,
   input  logic [3:0] sorted_num3,
   output logic [3:0] an_n,
   output logic [6:0] seg_n,
   output logic       displaying
);

   localparam int               CNT_W      = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(REFRESH_DIV - 1);

   logic             r_s1, r_s2, r_s3;
   logic [1:0]       r_prime;
   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [1:0]       r_idx, w_idx_nxt;
   logic [3:0]       r_num_q   [NUM_DIGITS];
   logic [3:0]       w_num_nxt [NUM_DIGITS];
   logic             w_cap, w_slot_tick, w_lit_nxt;
   logic [3:0]       w_dec_in, w_an_nxt;
   logic [6:0]       w_seg_dec, w_seg_nxt;

   // Edge detection is held off until s3 holds a post-reset sample, so a flag
   // already high across reset release is not mistaken for a rising edge.
   assign w_cap       = r_s2 & ~r_s3 & (r_prime == 2'd3);
   assign w_slot_tick = (r_cnt == c_cnt_last);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1    <= 1'b0;
         r_s2    <= 1'b0;
         r_s3    <= 1'b0;
         r_prime <= 2'd0;
      end else begin
         r_s1 <= start_display;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
         if (r_prime != 2'd3)
            r_prime <= r_prime + 2'd1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_num_nxt   = r_num_q;
      if (w_cap) begin
         w_state_nxt  = SCAN;
         w_cnt_nxt    = '0;
         w_idx_nxt    = 2'd0;
         w_num_nxt[0] = sorted_num0;
         w_num_nxt[1] = sorted_num1;
         w_num_nxt[2] = sorted_num2;
         w_num_nxt[3] = sorted_num3;
      end else if (r_state == SCAN) begin
         w_cnt_nxt = w_slot_tick ? '0 : r_cnt + CNT_W'(1);
         if (w_slot_tick)
            w_idx_nxt = r_idx + 2'd1;
      end
   end

`ifdef SORTED_DISPLAY_BLINK_EN
   localparam int               BLK_W      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [BLK_W-1:0] c_blk_last = BLK_W'(BLINK_DIV - 1);

   logic [BLK_W-1:0] r_blk_cnt, w_blk_cnt_nxt;
   logic             r_blink_on, w_blink_on_nxt;

   always_comb begin
      w_blk_cnt_nxt  = r_blk_cnt;
      w_blink_on_nxt = r_blink_on;
      if (w_cap) begin
         w_blk_cnt_nxt  = '0;
         w_blink_on_nxt = 1'b1;
      end else if (r_state == SCAN && w_slot_tick) begin
         if (r_blk_cnt == c_blk_last) begin
            w_blk_cnt_nxt  = '0;
            w_blink_on_nxt = ~r_blink_on;
         end else begin
            w_blk_cnt_nxt = r_blk_cnt + BLK_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_blk_cnt  <= '0;
         r_blink_on <= 1'b0;
      end else begin
         r_blk_cnt  <= w_blk_cnt_nxt;
         r_blink_on <= w_blink_on_nxt;
      end
   end

   assign w_lit_nxt = w_blink_on_nxt;
`else
   assign w_lit_nxt = 1'b1;
`endif

   // Decode the digit that will be selected next cycle so the pins are
   // registered yet update in the same cycle as the capture or slot change.
   assign w_dec_in = w_num_nxt[w_idx_nxt];

   hex_to_seg7 u_hex_to_seg7 (
      .hex   (w_dec_in),
      .seg_n (w_seg_dec)
   );

   always_comb begin
      w_an_nxt  = 4'b1111;
      w_seg_nxt = SEG_BLANK;
      if (w_state_nxt == SCAN && w_lit_nxt) begin
         w_an_nxt  = ~(4'b0001 << w_idx_nxt);
         w_seg_nxt = w_seg_dec;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_idx      <= 2'd0;
         for (int k = 0; k < NUM_DIGITS; k++)
            r_num_q[k] <= 4'd0;
         an_n       <= 4'b1111;
         seg_n      <= SEG_BLANK;
         displaying <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_idx      <= w_idx_nxt;
         for (int k = 0; k < NUM_DIGITS; k++)
            r_num_q[k] <= w_num_nxt[k];
         an_n       <= w_an_nxt;
         seg_n      <= w_seg_nxt;
         displaying <= (w_state_nxt == SCAN);
      end
   end

endmodule

`default_nettype wire
